// File: rtl/line_rotation_pkg.sv
// Shared constants for the line rotation scrambler/descrambler family.
package line_rotation_pkg;

  localparam int MODE_SCRAMBLER    = 0;
  localparam int MODE_DESCRAMBLER  = 1;
  localparam int LINE_SIZE_DEFAULT = 1440;

endpackage

// File: rtl/pingpong_line_ram.sv
// Two line buffers in one array: the writer fills bank `bank_sel` while the
// registered read port drains the opposite bank. Contents are never reset.
module pingpong_line_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bank_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  // Write port: one sample per clock into the writer bank
  always_ff @(posedge clk) begin
    mem[{bank_sel, wr_addr}] <= wr_data;
  end

  // Registered read port from the reader bank; only the output register resets
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[{~bank_sel, rd_addr}];
  end

endmodule

// File: rtl/param_line_rotator.sv
// Line rotation (cut-and-rotate) scrambler / descrambler for a video stream.
// MODE selects rotate-on-read (scrambler) or rotate-on-write (descrambler).
module param_line_rotator
  import line_rotation_pkg::*;
#(
  parameter int DATA_W        = 10,
  parameter int LINE_SIZE     = LINE_SIZE_DEFAULT,
  parameter int ADDR_W        = 11,
  parameter int MODE          = MODE_SCRAMBLER,
  parameter int GARBAGE_LINES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] cut_position,
  input  logic              enable,
  input  logic              V,
  input  logic              H,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              cut_error,
  output logic              overflow
);

  localparam int              CNT_W    = $clog2(GARBAGE_LINES + 1) + 1;
  localparam logic [ADDR_W:0]   LINE_X   = (ADDR_W+1)'(LINE_SIZE);
  localparam logic [ADDR_W-1:0] IDX_LINE = ADDR_W'(LINE_SIZE);
  localparam logic [ADDR_W-1:0] IDX_MAX  = '1;

  logic              h_prev;
  logic              h_fall;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] i_cur;
  logic              cut_bad;
  logic [ADDR_W-1:0] cut_new;
  logic [ADDR_W-1:0] cut_line_q;
  logic [ADDR_W-1:0] cut_prev_q;
  logic [ADDR_W-1:0] cut_cur;
  logic [ADDR_W-1:0] cut_prev;
  logic              sel_q;
  logic              sel_now;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  line_cnt;

  // Rotated index; the sum is kept one bit wider so it never wraps
  function automatic logic [ADDR_W-1:0] rotate(input logic [ADDR_W-1:0] idx,
                                               input logic [ADDR_W-1:0] cut,
                                               input logic              blank);
    logic [ADDR_W:0] sum;
    sum = {1'b0, idx} + {1'b0, cut};
    if (blank || ({1'b0, idx} >= LINE_X)) return idx;
    else if (sum < LINE_X)                return sum[ADDR_W-1:0];
    else                                  return ADDR_W'(sum - LINE_X);
  endfunction

  // Current-cycle view: on the H-fall cycle the new line's index, cut and
  // bank are already in force, so registers below simply track these values.
  always_comb begin
    h_fall   = h_prev & ~H;
    i_cur    = h_fall ? '0 : idx_q;
    cut_bad  = {1'b0, cut_position} >= LINE_X;
    cut_new  = (enable && !V && !cut_bad) ? cut_position : '0;
    cut_cur  = h_fall ? cut_new : cut_line_q;
    cut_prev = h_fall ? cut_line_q : cut_prev_q;
    sel_now  = h_fall ? ~sel_q : sel_q;
    wr_addr  = i_cur;
    rd_addr  = i_cur;
    if (MODE == MODE_DESCRAMBLER) wr_addr = rotate(i_cur, cut_cur, H);
    else                          rd_addr = rotate(i_cur, cut_prev, H);
  end

  // H edge history and saturating sample index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_prev <= H;
      idx_q  <= H ? IDX_LINE : '0;
    end else begin
      h_prev <= H;
      idx_q  <= (i_cur == IDX_MAX) ? IDX_MAX : i_cur + ADDR_W'(1);
    end
  end

  // Per-line cut registers, bank select and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cut_line_q <= '0;
      cut_prev_q <= '0;
      sel_q      <= 1'b0;
      cut_error  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cut_line_q <= cut_cur;
      cut_prev_q <= cut_prev;
      sel_q      <= sel_now;
      cut_error  <= h_fall & cut_bad;
      overflow   <= ~h_fall & (overflow | (i_cur == IDX_MAX));
    end
  end

  // Garbage-line counter; data_valid is sticky until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt   <= '0;
      data_valid <= 1'b0;
    end else if (h_fall) begin
      if (line_cnt == CNT_W'(GARBAGE_LINES)) data_valid <= 1'b1;
      else                                   line_cnt   <= line_cnt + CNT_W'(1);
    end
  end

  pingpong_line_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .reset_n  (reset_n),
    .bank_sel (sel_now),
    .wr_addr  (wr_addr),
    .wr_data  (data_in),
    .rd_addr  (rd_addr),
    .rd_data  (data_out)
  );

endmodule

// File: tb/tb_param_line_rotator.sv
// Scrambler followed by descrambler; a line-buffer model predicts both outputs.
module tb_param_line_rotator;

  localparam int DW   = 12;
  localparam int AW   = 11;
  localparam int LINE = 1440;
  localparam int DEP  = 2048;
  localparam int BLK  = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data_in;
  logic [AW-1:0] cut_position;
  logic          enable, V, H;
  logic [DW-1:0] data_out;
  logic          data_valid, cut_error, overflow;

  logic          h_d;
  logic [AW-1:0] desc_cut;
  logic [DW-1:0] desc_out;
  logic          desc_valid, desc_err, desc_ovf;

  always #5 clk = ~clk;
  always @(posedge clk) h_d <= H;

  param_line_rotator #(
    .DATA_W (DW), .LINE_SIZE (LINE), .ADDR_W (AW), .MODE (0), .GARBAGE_LINES (1)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .data_in (data_in), .cut_position (cut_position),
    .enable (enable), .V (V), .H (H), .data_out (data_out), .data_valid (data_valid),
    .cut_error (cut_error), .overflow (overflow)
  );

  param_line_rotator #(
    .DATA_W (DW), .LINE_SIZE (LINE), .ADDR_W (AW), .MODE (1), .GARBAGE_LINES (1)
  ) u_desc (
    .clk (clk), .reset_n (reset_n), .data_in (data_out), .cut_position (desc_cut),
    .enable (1'b1), .V (1'b0), .H (h_d), .data_out (desc_out), .data_valid (desc_valid),
    .cut_error (desc_err), .overflow (desc_ovf)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          chk;
    logic          valid;
    logic          err;
    logic          ovf;
    logic          spot;
    logic [AW-1:0] idx;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          chk;
  } dexp_t;

  exp_t  sb[$];
  dexp_t sb_desc[$];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] cur_line  [DEP];
  logic [DW-1:0] prev_line [DEP];
  logic [DW-1:0] prev2_line[DEP];
  int  cnt, cur_cut, prev_cut, idx_m, cur_tag, prev_tag, next_tag;
  bit  hprev_m, ovf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cnt      = 0;
    cur_cut  = 0;
    prev_cut = 0;
    cur_tag  = 0;
    prev_tag = 0;
    hprev_m  = H;
    idx_m    = H ? LINE : 0;
    ovf_m    = 1'b0;
    sb_desc.delete();
  endtask

  task automatic drive_sample(input bit h, input bit v, input logic [DW-1:0] d,
                              input int cut, input bit en);
    exp_t  e;
    dexp_t de;
    bit    hfall;
    int    i, ri;
    H = h; V = v; data_in = d; cut_position = AW'(cut); enable = en;
    hfall = hprev_m && !h;
    if (hfall) begin
      i          = 0;
      cnt++;
      prev2_line = prev_line;
      prev_line  = cur_line;
      prev_cut   = cur_cut;
      cur_cut    = (en && !v && cut < LINE) ? cut : 0;
      prev_tag   = cur_tag;
      cur_tag    = next_tag;
      desc_cut   = AW'(prev_cut);
      ovf_m      = 1'b0;
    end else begin
      i = idx_m;
    end
    ri = (!h && i < LINE) ? (i + prev_cut) % LINE : i;
    e.data  = prev_line[ri];
    e.chk   = (cnt >= 2);
    e.valid = (cnt >= 2);
    e.err   = hfall && (cut >= LINE);
    if (i == DEP - 1) ovf_m = 1'b1;
    e.ovf   = ovf_m;
    e.spot  = (prev_tag == 1) && !h;
    e.idx   = AW'(i);
    de.data = prev2_line[i];
    de.chk  = (cnt >= 3);
    cur_line[i] = d;
    idx_m   = (i == DEP - 1) ? i : i + 1;
    hprev_m = h;
    sb.push_back(e);
    sb_desc.push_back(de);

    @(posedge clk);
    @(negedge clk);

    e = sb.pop_front();
    check("data_valid", data_valid, e.valid);
    check("cut_error", cut_error, e.err);
    check("overflow", overflow, e.ovf);
    if (e.chk) check("data_out", data_out, e.data);
    if (e.spot && e.idx == 0)    check("cut100_idx0", data_out, 100);
    if (e.spot && e.idx == 1339) check("cut100_idx1339", data_out, 1439);
    if (e.spot && e.idx == 1340) check("cut100_idx1340", data_out, 0);
    check("desc_cut_error", desc_err, 0);
    if (sb_desc.size() >= 2) begin
      de = sb_desc.pop_front();
      if (de.chk) check("cascade_data", desc_out, de.data);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_cut_error", cut_error, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic drive_line(input int cut, input bit en, input bit v, input bit ramp,
                            input int blank, input int tag, input int reset_at);
    next_tag = tag;
    for (int s = 0; s < LINE; s++) begin
      if (s == reset_at) pulse_reset();
      drive_sample(1'b0, v, ramp ? DW'(s) : DW'($urandom_range(0, 4095)), cut, en);
    end
    for (int b = 0; b < blank; b++)
      drive_sample(1'b1, v, DW'($urandom_range(0, 4095)), cut, en);
  endtask

  initial begin
    reset_n = 1'b0; H = 1'b1; V = 1'b1; data_in = '0;
    cut_position = '0; enable = 1'b0; desc_cut = '0; next_tag = 0;
    for (int k = 0; k < DEP; k++) begin
      cur_line[k] = '0; prev_line[k] = '0; prev2_line[k] = '0;
    end
    repeat (4) @(negedge clk);
    #1;
    check("init_data_out", data_out, 0);
    check("init_data_valid", data_valid, 0);
    check("init_cut_error", cut_error, 0);
    check("init_overflow", overflow, 0);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++) drive_sample(1'b1, 1'b1, DW'($urandom_range(0, 4095)), 0, 1'b0);

    drive_line(0,    1'b1, 1'b0, 1'b1, BLK, 0, -1);
    drive_line(0,    1'b1, 1'b0, 1'b1, BLK, 0, -1);
    drive_line(100,  1'b1, 1'b0, 1'b1, BLK, 1, -1);
    drive_line(1500, 1'b1, 1'b0, 1'b0, BLK, 0, -1);
    drive_line(50,   1'b0, 1'b0, 1'b0, BLK, 0, -1);
    drive_line(200,  1'b1, 1'b1, 1'b0, BLK, 0, -1);
    drive_line(723,  1'b1, 1'b0, 1'b1, BLK, 0, -1);
    drive_line(723,  1'b1, 1'b0, 1'b1, BLK, 0, -1);
    drive_line(723,  1'b1, 1'b0, 1'b0, BLK, 0, -1);
    drive_line(1439, 1'b1, 1'b0, 1'b0, 700, 0, -1);
    drive_line($urandom_range(0, 1439), 1'b1, 1'b0, 1'b0, BLK, 0, -1);
    drive_line(5,    1'b1, 1'b0, 1'b0, BLK, 0, 700);
    for (int n = 0; n < 5; n++)
      drive_line($urandom_range(0, 1439), 1'b1, 1'b0, 1'b0, BLK, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_line_rotator.md
PARAM_LINE_ROTATOR -- requirements
Module: param_line_rotator

Interface
REQ-001 SHALL have parameter DATA_W, default 10, sample width in bits.
REQ-002 SHALL have parameter LINE_SIZE, default 1440, active samples per line (rotation modulus).
REQ-003 SHALL have parameter ADDR_W, default 11, buffer address width; 2**ADDR_W SHALL be >= LINE_SIZE + max blanking samples.
REQ-004 SHALL have parameter MODE, default 0: 0 = scrambler (rotate on read), 1 = descrambler (rotate on write).
REQ-005 SHALL have parameter GARBAGE_LINES, default 1, lines discarded before data_valid.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  DATA_W  video sample stream, one sample per clk.
REQ-009 cut_position  input  ADDR_W  rotation amount for the next line, sampled at H fall.
REQ-010 enable  input  1  rotation enable, sampled at H fall; 0 = pass line with zero rotation.
REQ-011 V  input  1  vertical blanking flag; high = blanking line.
REQ-012 H  input  1  horizontal blanking flag; high->low edge (H fall) = start of active line.
REQ-013 data_out  output  DATA_W  rotated stream, registered.
REQ-014 data_valid  output  1  high once GARBAGE_LINES lines have passed.
REQ-015 cut_error  output  1  one-cycle pulse: sampled cut_position >= LINE_SIZE.
REQ-016 overflow  output  1  sticky until next H fall: write index reached 2**ADDR_W-1.

Function
REQ-017 SHALL use two ping-pong line buffers of 2**ADDR_W x DATA_W; writer fills one while reader drains the other; roles swap at every H fall.
REQ-018 Index i SHALL be 0 on the H-fall cycle and increment by 1 per clk, saturating at 2**ADDR_W-1 (overflow set).
REQ-019 At H fall SHALL latch cut_eff = cut_position if enable=1, V=0 and cut_position < LINE_SIZE; otherwise cut_eff = 0.
REQ-020 cut_position >= LINE_SIZE SHALL give cut_eff = 0 and pulse cut_error the following cycle.
REQ-021 Rotated index r(i) = i + cut_eff if i + cut_eff < LINE_SIZE, else i + cut_eff - LINE_SIZE, for i < LINE_SIZE and H=0; r(i) = i otherwise (blanking not rotated).
REQ-022 MODE 0: write buffer[i] <= data_in; data_out <= other buffer[r(i)] with cut_eff of the previous line.
REQ-023 MODE 1: write buffer[r(i)] <= data_in with cut_eff of the current line; data_out <= other buffer[i].
REQ-024 Latency: data_out for index i of line n+1 SHALL appear one clk after data_in index i of line n+1; end-to-end one line period + 1 clk.
REQ-025 Addition SHALL be computed at ADDR_W+1 bits; no modulo-2**ADDR_W wrap permitted.
REQ-026 Short line (H fall before LINE_SIZE samples): unwritten locations SHALL output stale contents; no error flag.
REQ-027 data_valid SHALL rise at the (GARBAGE_LINES+1)-th H fall after reset and stay high until reset.
REQ-028 V high lines SHALL still swap buffers and count toward GARBAGE_LINES.
REQ-029 H fall and cut_position change in the same cycle: the new cut_position SHALL be used.

Reset
REQ-030 reset_n low SHALL asynchronously clear data_out, data_valid, cut_error, overflow, line counter, cut_eff registers and buffer select to 0.
REQ-031 At reset, index SHALL load 0 if H=0, else LINE_SIZE; H/V edge-history registers load current H/V (no false edge on release).
REQ-032 Buffer RAM contents SHALL not be reset.
REQ-033 Reset mid-line SHALL discard the line; output resumes after GARBAGE_LINES+1 further H falls.

Structure
REQ-034 MODE_SCRAMBLER/MODE_DESCRAMBLER constants and default LINE_SIZE SHALL live in shared package line_rotation_pkg.
REQ-035 Buffers SHALL be one sub-module pingpong_line_ram (one write port, one registered read port, bank select input).

Verification
REQ-036 MODE 0, cut=0, ramp 0..1439 -> next line output identical ramp, data_valid high from 2nd H fall.
REQ-037 MODE 0, cut=100 -> output index 0 = 100, index 1339 = 1439, index 1340 = 0.
REQ-038 MODE 0 then MODE 1, cut=723 in both -> cascade restores original ramp two lines later.
REQ-039 cut=1500 -> cut_error one pulse, line passed unrotated; enable=0 with cut=50 -> unrotated, no error.
REQ-040 V=1 line with cut=200 -> unrotated; blanking samples i >= 1440 output in order.
REQ-041 reset_n pulsed low at sample 700 -> outputs 0 immediately, data_valid low until 2nd subsequent H fall.
